// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with a valid/ack output handshake.
//
// Parameters: DATA_BITS (5..9, LSB first), OVERSAMPLE (even, 8..32 ticks per bit),
//             PARITY_MODE (0 none, 1 even, 2 odd), STOP_BITS (1 or 2).
// Optional feature macro: UART_RX_MAJORITY_EN. When defined, each bit is the 2-of-3 majority
//   of rx_s at the mid-point and the ticks on either side of it. The decision is taken one
//   tick after the mid-point.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   clk_en     in   oversample tick, OVERSAMPLE per bit
//   rx         in   asynchronous serial line, idle high
//   dout       out  received data word
//   dout_valid out  dout and status flags hold a frame
//   dout_ack   in   consumer accepts the frame when high together with dout_valid
//   parity_err out  parity mismatch for the frame in dout
//   frame_err  out  a checked stop bit was sampled low
//   break_det  out  frame_err with all data bits and the parity bit (if any) low
//   overrun    out  sticky, a frame was overwritten before it was acked
module uart_rx_param #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = 4;
  localparam logic [SW-1:0] SLast = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMid  = SW'(OVERSAMPLE / 2);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] SPre  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SDec  = SW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [SW-1:0] SDec  = SMid;
`endif
  localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [SW-1:0]        s_q, s_d, s_inc;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_q, ferr_d;
  logic                 deliver_q, deliver_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 samp;
  logic                 par_x, perr_new, brk_new, accept;

`ifdef UART_RX_MAJORITY_EN
  // Samples taken one tick before and at the mid-point; the third vote is the live rx_s.
  logic [1:0] maj_q, maj_d;

  always_comb begin
    maj_d = maj_q;
    if (clk_en) begin
      if (s_q == SPre) maj_d[0] = rx_s_q;
      if (s_q == SMid) maj_d[1] = rx_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) maj_q <= 2'b11;
    else        maj_q <= maj_d;
  end

  assign samp = (maj_q[0] & maj_q[1]) | (rx_s_q & (maj_q[0] | maj_q[1]));
`else
  assign samp = rx_s_q;
`endif

  assign s_inc = (s_q == SLast) ? '0 : s_q + 1'b1;

  // Receive FSM and counters, frozen between oversample ticks.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    bcnt_d    = bcnt_q;
    data_d    = data_q;
    par_bit_d = par_bit_q;
    ferr_d    = ferr_q;
    deliver_d = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        StIdle: begin
          s_d    = '0;
          bcnt_d = '0;
          if (!rx_s_q) begin
            state_d = StStart;
            ferr_d  = 1'b0;
          end
        end
        StStart: begin
          s_d = s_inc;
          if (s_q == SDec && samp) begin
            // Line returned high before mid-bit: a glitch, not a start bit.
            state_d = StIdle;
            s_d     = '0;
          end else if (s_q == SLast) begin
            state_d = StData;
            bcnt_d  = '0;
          end
        end
        StData: begin
          s_d = s_inc;
          if (s_q == SDec) begin
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
              if (bcnt_q == BW'(i)) data_d[i] = samp;
            end
          end
          if (s_q == SLast) begin
            if (bcnt_q == DataLast) begin
              bcnt_d  = '0;
              state_d = (PARITY_MODE != 0) ? StParity : StStop;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          s_d = s_inc;
          if (s_q == SDec) par_bit_d = samp;
          if (s_q == SLast) begin
            state_d = StStop;
            bcnt_d  = '0;
          end
        end
        StStop: begin
          s_d = s_inc;
          if (s_q == SDec) begin
            if (!samp) ferr_d = 1'b1;
            // Leave at mid-point of the last stop bit so the next start edge is caught early.
            if (bcnt_q == StopLast) begin
              deliver_d = 1'b1;
              state_d   = StIdle;
              s_d       = '0;
            end
          end else if (s_q == SLast) begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign par_x    = (^data_q) ^ par_bit_q;
  assign perr_new = (PARITY_MODE == 1) ? par_x : (PARITY_MODE == 2) ? ~par_x : 1'b0;
  assign brk_new  = ferr_q & ~(|data_q) & ((PARITY_MODE == 0) | ~par_bit_q);
  assign accept   = valid_q & dout_ack;

  // Output handshake, evaluated every clock.
  always_comb begin
    dout_d     = dout_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_out_d = ferr_out_q;
    brk_d      = brk_q;
    ovr_d      = ovr_q;
    if (deliver_q) begin
      dout_d     = data_q;
      perr_d     = perr_new;
      ferr_out_d = ferr_q;
      brk_d      = brk_new;
      valid_d    = 1'b1;
      if (valid_q && !dout_ack) ovr_d = 1'b1;
      else if (accept)          ovr_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= StIdle;
      s_q        <= '0;
      bcnt_q     <= '0;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      ferr_q     <= 1'b0;
      deliver_q  <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      s_q        <= s_d;
      bcnt_q     <= bcnt_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      ferr_q     <= ferr_d;
      deliver_q  <= deliver_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_out_q <= ferr_out_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_out_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8N1 and 8E2) share clock, tick and reset; each has
// its own rx line and ack. A frame-level model predicts every output on every clock.
module tb_uart_rx_param;

  localparam int OS = 16;
  localparam int M  = OS / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = M + 1;
`else
  localparam int DEC = M;
`endif
  // The receiver counts a bit from the tick after the one that saw the start edge, so its
  // decision tick lands one bench tick later within each bit.
  localparam int BDEC = DEC + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       rx [2];
  logic       ack [2];
  logic [7:0] dout_w [2];
  logic       valid_w [2];
  logic       perr_w [2];
  logic       ferr_w [2];
  logic       brk_w [2];
  logic       ovr_w [2];

  int vec = 0;
  int miss = 0;
  bit chk_on = 1'b0;
  bit ack_rand = 1'b0;
  int ack_at_deliver = -1;

  // Frame-level model state.
  logic [7:0] exp_dout [2];
  logic       exp_valid [2];
  logic       exp_perr [2];
  logic       exp_ferr [2];
  logic       exp_brk [2];
  logic       exp_ovr [2];
  logic [7:0] pend_dout [2];
  logic       pend_perr [2];
  logic       pend_ferr [2];
  logic       pend_brk [2];
  int         pend_seq [2];
  int         done_seq [2];

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .rx         (rx[0]),
    .dout       (dout_w[0]),
    .dout_valid (valid_w[0]),
    .dout_ack   (ack[0]),
    .parity_err (perr_w[0]),
    .frame_err  (ferr_w[0]),
    .break_det  (brk_w[0]),
    .overrun    (ovr_w[0])
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(2)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .rx         (rx[1]),
    .dout       (dout_w[1]),
    .dout_valid (valid_w[1]),
    .dout_ack   (ack[1]),
    .parity_err (perr_w[1]),
    .frame_err  (ferr_w[1]),
    .break_det  (brk_w[1]),
    .overrun    (ovr_w[1])
  );

  always #5 clk = ~clk;

  function automatic int par_of(input int inst);
    return (inst == 0) ? 0 : 1;
  endfunction

  function automatic int stop_of(input int inst);
    return (inst == 0) ? 1 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a posted frame lands one clock after the decision tick; ack handshake every clock.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        exp_dout[i]  <= 8'h00;
        exp_valid[i] <= 1'b0;
        exp_perr[i]  <= 1'b0;
        exp_ferr[i]  <= 1'b0;
        exp_brk[i]   <= 1'b0;
        exp_ovr[i]   <= 1'b0;
        done_seq[i]  <= pend_seq[i];
      end else if (pend_seq[i] != done_seq[i]) begin
        done_seq[i]  <= pend_seq[i];
        exp_dout[i]  <= pend_dout[i];
        exp_perr[i]  <= pend_perr[i];
        exp_ferr[i]  <= pend_ferr[i];
        exp_brk[i]   <= pend_brk[i];
        exp_valid[i] <= 1'b1;
        if (exp_valid[i]) exp_ovr[i] <= !ack[i];
      end else if (exp_valid[i] && ack[i]) begin
        exp_valid[i] <= 1'b0;
        exp_ovr[i]   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("outs%0d", i),
              {valid_w[i], ovr_w[i], perr_w[i], ferr_w[i], brk_w[i], dout_w[i]},
              {exp_valid[i], exp_ovr[i], exp_perr[i], exp_ferr[i], exp_brk[i], exp_dout[i]});
      end
    end
  end

  task automatic clk_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) ack[i] = ack_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // One oversample period: rx settles through the synchroniser before the tick edge.
  task automatic tick(input int inst, input logic v);
    rx[inst]     = v;
    rx[1 - inst] = 1'b1;
    clk_en = 1'b0;
    clk_step();
    clk_step();
    clk_step();
    clk_en = 1'b1;
    clk_step();
    clk_en = 1'b0;
  endtask

  task automatic idle(input int inst, input int n);
    repeat (n) tick(inst, 1'b1);
  endtask

  task automatic ack_pulse(input int inst);
    ack[inst] = 1'b1;
    clk_step();
  endtask

  task automatic send_frame(input int inst, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops, input bit flip);
    logic bits [16];
    int   nb;
    int   p;
    logic v;
    logic fe;
    p  = par_of(inst);
    nb = 9;
    fe = 1'b0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
    if (p != 0) begin
      bits[nb] = pbit;
      nb++;
    end
    for (int j = 0; j < stop_of(inst); j++) begin
      bits[nb] = stops[j];
      nb++;
      if (!stops[j]) fe = 1'b1;
    end
    for (int b = 0; b < nb; b++) begin
      for (int s = 0; s < OS; s++) begin
        v = bits[b];
        if (flip && b >= 1 && b <= 8 && s == M + 1) v = ~v;
        tick(inst, v);
        if (b == nb - 1 && s == BDEC) begin
          pend_dout[inst] = data;
          pend_perr[inst] = (p == 1) ? ((^data) ^ pbit) : (p == 2) ? ~((^data) ^ pbit) : 1'b0;
          pend_ferr[inst] = fe;
          pend_brk[inst]  = fe && (data == 8'h00) && (p == 0 || pbit == 1'b0);
          pend_seq[inst]  = pend_seq[inst] + 1;
          if (ack_at_deliver == inst) ack[inst] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] st;
    int         inst;
    rx[0] = 1'b1;
    rx[1] = 1'b1;
    ack[0] = 1'b0;
    ack[1] = 1'b0;
    pend_seq[0] = 0;
    pend_seq[1] = 0;
    reset = 1'b0;
    clk_step();
    clk_step();
    chk_on = 1'b1;
    clk_step();
    check("reset_a", {valid_w[0], ovr_w[0], perr_w[0], ferr_w[0], brk_w[0], dout_w[0]}, 0);
    check("reset_b", {valid_w[1], ovr_w[1], perr_w[1], ferr_w[1], brk_w[1], dout_w[1]}, 0);
    reset = 1'b1;
    idle(0, 4);

    // Basic 8N1 frame and ack.
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b0);
    check("a5_frame", {valid_w[0], perr_w[0], ferr_w[0], brk_w[0], dout_w[0]},
          {1'b1, 3'b000, 8'hA5});
    ack_pulse(0);
    check("a5_ack", {valid_w[0], dout_w[0]}, {1'b0, 8'hA5});

    // Even parity: 0x03 needs parity bit 0.
    send_frame(1, 8'h03, 1'b1, 2'b11, 1'b0);
    check("par_bad", {perr_w[1], dout_w[1]}, {1'b1, 8'h03});
    ack_pulse(1);
    send_frame(1, 8'h03, 1'b0, 2'b11, 1'b0);
    check("par_good", {valid_w[1], perr_w[1], dout_w[1]}, {1'b1, 1'b0, 8'h03});
    ack_pulse(1);

    // Start glitch then a clean frame.
    repeat (4) tick(0, 1'b0);
    idle(0, 2 * OS);
    check("glitch", {30'd0, valid_w[0]}, 0);
    send_frame(0, 8'h5A, 1'b0, 2'b11, 1'b0);
    check("after_glitch", {valid_w[0], dout_w[0]}, {1'b1, 8'h5A});
    ack_pulse(0);

    // Break, then second stop bit low on the two-stop instance.
    send_frame(0, 8'h00, 1'b0, 2'b00, 1'b0);
    idle(0, 2 * OS);
    check("break", {valid_w[0], ferr_w[0], brk_w[0], dout_w[0]}, {3'b111, 8'h00});
    ack_pulse(0);
    send_frame(1, 8'h81, 1'b0, 2'b01, 1'b0);
    idle(1, 2 * OS);
    check("stop2_low", {ferr_w[1], brk_w[1], perr_w[1], dout_w[1]}, {3'b100, 8'h81});
    ack_pulse(1);

    // Overrun, ack clearing it, and delivery coincident with ack.
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0);
    send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0);
    check("overrun", {valid_w[0], ovr_w[0], dout_w[0]}, {2'b11, 8'h22});
    ack_pulse(0);
    check("overrun_ack", {valid_w[0], ovr_w[0]}, 0);
    send_frame(0, 8'h33, 1'b0, 2'b11, 1'b0);
    ack_at_deliver = 0;
    send_frame(0, 8'h44, 1'b0, 2'b11, 1'b0);
    ack_at_deliver = -1;
    check("deliver_ack", {valid_w[0], ovr_w[0], dout_w[0]}, {2'b10, 8'h44});

    // Reset in the middle of the data bits of 0xFF.
    repeat (OS) tick(0, 1'b0);
    repeat (3 * OS) tick(0, 1'b1);
    reset = 1'b0;
    clk_step();
    clk_step();
    check("mid_reset", {valid_w[0], ovr_w[0], perr_w[0], ferr_w[0], brk_w[0], dout_w[0]}, 0);
    reset = 1'b1;
    idle(0, 2 * OS);
    send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b0);
    check("post_reset", {valid_w[0], dout_w[0]}, {1'b1, 8'h3C});
    ack_pulse(0);
`ifdef UART_RX_MAJORITY_EN
    send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b1);
    check("majority", {valid_w[0], dout_w[0]}, {1'b1, 8'h3C});
    ack_pulse(0);
`endif

    // Random frames on both instances with random ack traffic.
    ack_rand = 1'b1;
    for (int k = 0; k < 16; k++) begin
      inst = int'($urandom_range(0, 1));
      d    = 8'($urandom);
      st   = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
      send_frame(inst, d, 1'($urandom), st, 1'b0);
      idle(inst, OS + int'($urandom_range(0, 8)));
    end
    ack_rand = 1'b0;
    clk_step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
